// File: rtl/mac_unload_pkg.sv
// Shared widths and FSM state type for the MAC result byte unloader.
package mac_unload_pkg;

   localparam int WORD_W = 16;
   localparam int BYTE_W = 8;

   // IDLE: nothing presented; FIRST/SECOND: which half of hold is on out_byte
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FIRST  = 2'd1,
      SECOND = 2'd2
   } unload_state_t;

endpackage

// File: rtl/word_fifo.sv
// Small synchronous word FIFO. Pointers and count reset asynchronously;
// the storage array is left unreset because it is only read when count != 0.
// Push is ignored when full and pop is ignored when empty.
module word_fifo #(
   parameter int DEPTH  = 2,
   parameter int WORD_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic [WORD_W-1:0]       push_data,
   input  logic                    pop,
   output logic [WORD_W-1:0]       pop_data,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WORD_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full     = (count == DEPTH_C);
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Storage write at the tail
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mac_byte_unloader.sv
// Byte-serial unloader: buffers 16-bit MAC results in a word FIFO and
// emits each as two bytes on a valid/ready byte port.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid && ready; valid, once high, stays high with stable data until that
// transfer. in_ready, out_valid, out_byte and out_last come from registered
// state only (in_ready is additionally gated low by rst).
module mac_byte_unloader
   import mac_unload_pkg::*;
#(
   parameter int DEPTH     = 2,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WORD_W-1:0]   in_word,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [BYTE_W-1:0]   out_byte,
   output logic                out_last,
   output logic                busy,
   output logic [7:0]          words_sent,
   output unload_state_t       dbg_state
);

   unload_state_t            state;
   unload_state_t            next_state;
   logic [WORD_W-1:0]        hold;
   logic [WORD_W-1:0]        fifo_head;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic [$clog2(DEPTH):0]   fifo_count;
   logic                     load;
   logic                     sent_inc;
   logic [BYTE_W-1:0]        first_byte;
   logic [BYTE_W-1:0]        second_byte;

   assign in_ready  = !fifo_full && !rst;
   assign busy      = (state != IDLE) || (fifo_count != '0);
   assign dbg_state = state;

   assign first_byte  = MSB_FIRST ? hold[WORD_W-1:BYTE_W] : hold[BYTE_W-1:0];
   assign second_byte = MSB_FIRST ? hold[BYTE_W-1:0]      : hold[WORD_W-1:BYTE_W];

   word_fifo #(
      .DEPTH  (DEPTH),
      .WORD_W (WORD_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (in_valid && in_ready),
      .push_data (in_word),
      .pop       (load),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next state, FIFO pop and byte-port outputs
   always_comb begin
      next_state = state;
      load       = 1'b0;
      sent_inc   = 1'b0;
      out_valid  = 1'b0;
      out_last   = 1'b0;
      out_byte   = '0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               load       = 1'b1;
               next_state = FIRST;
            end
         end
         FIRST: begin
            out_valid = 1'b1;
            out_byte  = first_byte;
            if (out_ready) next_state = SECOND;
         end
         SECOND: begin
            out_valid = 1'b1;
            out_last  = 1'b1;
            out_byte  = second_byte;
            if (out_ready) begin
               sent_inc = 1'b1;
               // Chain straight into the next word so there is no idle bubble
               if (!fifo_empty) begin
                  load       = 1'b1;
                  next_state = FIRST;
               end else begin
                  next_state = IDLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Hold register: only changes when a word is taken from the FIFO
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       hold <= '0;
      else if (load) hold <= fifo_head;
   end

   // Completed-word counter, wraps 255 -> 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           words_sent <= '0;
      else if (sent_inc) words_sent <= words_sent + 8'd1;
   end

endmodule

// File: tb/tb_mac_byte_unloader.sv
// Bench for mac_byte_unloader: one MSB-first and one LSB-first instance.
// A negedge scoreboard turns every accepted word into its two expected bytes
// and checks every accepted byte, busy and words_sent; scenario tasks add
// cycle-exact checks.
module tb_mac_byte_unloader;
  import mac_unload_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // MSB-first instance
  logic          in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [15:0]   in_word;
  logic [7:0]    out_byte, words_sent;
  unload_state_t dbg_state;
  // LSB-first instance
  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_busy;
  logic [15:0]   b_in_word;
  logic [7:0]    b_out_byte, b_words_sent;
  unload_state_t b_dbg_state;

  mac_byte_unloader #(.DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte), .out_last(out_last),
    .busy(busy), .words_sent(words_sent), .dbg_state(dbg_state)
  );

  mac_byte_unloader #(.DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_word(b_in_word),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_byte(b_out_byte), .out_last(b_out_last),
    .busy(b_busy), .words_sent(b_words_sent), .dbg_state(b_dbg_state)
  );

  int vectors = 0;
  int miscompares = 0;

  // Expected byte stream entries are {last, byte}
  logic [8:0] exp_q[$];
  logic [8:0] exp_b_q[$];
  int         model_sent = 0;
  int         model_b_sent = 0;
  logic [8:0] mon_e;

  // Scoreboard: sampled mid-cycle, describes the transfers of the coming edge
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_b_q.delete();
      model_sent = 0;
      model_b_sent = 0;
    end else begin
      vectors++;
      if (busy !== (exp_q.size() != 0)) begin
        miscompares++;
        $display("FAIL sb_busy: busy=%b want %b", busy, exp_q.size() != 0);
      end
      vectors++;
      if (words_sent !== 8'(model_sent)) begin
        miscompares++;
        $display("FAIL sb_words_sent: got %0d want %0d", words_sent, 8'(model_sent));
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({1'b0, in_word[15:8]});
        exp_q.push_back({1'b1, in_word[7:0]});
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_byte: unexpected byte %h last=%b, want none", out_byte, out_last);
        end else begin
          mon_e = exp_q.pop_front();
          if ({out_last, out_byte} !== mon_e) begin
            miscompares++;
            $display("FAIL sb_byte: got last=%b byte=%h want last=%b byte=%h",
                     out_last, out_byte, mon_e[8], mon_e[7:0]);
          end
          if (mon_e[8]) model_sent++;
        end
      end

      vectors++;
      if (b_busy !== (exp_b_q.size() != 0)) begin
        miscompares++;
        $display("FAIL sb_b_busy: busy=%b want %b", b_busy, exp_b_q.size() != 0);
      end
      vectors++;
      if (b_words_sent !== 8'(model_b_sent)) begin
        miscompares++;
        $display("FAIL sb_b_words_sent: got %0d want %0d", b_words_sent, 8'(model_b_sent));
      end
      if (b_in_valid && b_in_ready) begin
        exp_b_q.push_back({1'b0, b_in_word[7:0]});
        exp_b_q.push_back({1'b1, b_in_word[15:8]});
      end
      if (b_out_valid && b_out_ready) begin
        vectors++;
        if (exp_b_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_b_byte: unexpected byte %h last=%b, want none", b_out_byte, b_out_last);
        end else begin
          mon_e = exp_b_q.pop_front();
          if ({b_out_last, b_out_byte} !== mon_e) begin
            miscompares++;
            $display("FAIL sb_b_byte: got last=%b byte=%h want last=%b byte=%h",
                     b_out_last, b_out_byte, mon_e[8], mon_e[7:0]);
          end
          if (mon_e[8]) model_b_sent++;
        end
      end
    end
  end

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #2;
    vectors++;
    if ({out_valid, out_last, busy, in_ready} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: valid/last/busy/in_ready=%b want 0000",
               {out_valid, out_last, busy, in_ready});
    end
    vectors++;
    if (out_byte !== 8'h00 || words_sent !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_values: out_byte=%h words_sent=%0d want 00 0", out_byte, words_sent);
    end
    vectors++;
    if (dbg_state !== IDLE) begin
      miscompares++;
      $display("FAIL reset_state: state=%0d want IDLE", dbg_state);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: in_ready=%b/%b want 1/1", in_ready, b_in_ready);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_word   = 16'hA55A;
    tick();                       // edge N: word accepted
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_n: out_valid=%b busy=%b want 0 1", out_valid, busy);
    end
    tick();                       // edge N+1: loaded
    vectors++;
    if ({out_valid, out_last, out_byte} !== {2'b10, 8'hA5}) begin
      miscompares++;
      $display("FAIL single_b0: valid=%b last=%b byte=%h want 1 0 a5", out_valid, out_last, out_byte);
    end
    tick();                       // edge N+2: first byte transferred
    vectors++;
    if ({out_valid, out_last, out_byte} !== {2'b11, 8'h5A}) begin
      miscompares++;
      $display("FAIL single_b1: valid=%b last=%b byte=%h want 1 1 5a", out_valid, out_last, out_byte);
    end
    tick();                       // edge N+3: second byte transferred
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || words_sent !== 8'd1) begin
      miscompares++;
      $display("FAIL single_done: valid=%b busy=%b words_sent=%0d want 0 0 1", out_valid, busy, words_sent);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_word   = 16'h1234;
    tick();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({out_valid, out_last, out_byte} !== {2'b10, 8'h12}) begin
        miscompares++;
        $display("FAIL bp_hold%0d: valid=%b last=%b byte=%h want 1 0 12", i, out_valid, out_last, out_byte);
      end
      tick();
    end
    out_ready = 1'b1;
    vectors++;
    if ({out_valid, out_last, out_byte} !== {2'b10, 8'h12}) begin
      miscompares++;
      $display("FAIL bp_release: valid=%b last=%b byte=%h want 1 0 12", out_valid, out_last, out_byte);
    end
    tick();
    vectors++;
    if ({out_valid, out_last, out_byte} !== {2'b11, 8'h34}) begin
      miscompares++;
      $display("FAIL bp_second: valid=%b last=%b byte=%h want 1 1 34", out_valid, out_last, out_byte);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || words_sent !== 8'd2) begin
      miscompares++;
      $display("FAIL bp_done: valid=%b words_sent=%0d want 0 2", out_valid, words_sent);
    end
  endtask

  task automatic test_fill();
    logic [7:0] fill_exp [6] = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      in_word  = 16'(i);
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL fill_accept%0d: in_ready=%b want 1", i, in_ready);
      end
      tick();
    end
    in_word = 16'h0004;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_full: in_ready=%b want 0", in_ready);
    end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_byte !== fill_exp[i]) begin
        miscompares++;
        $display("FAIL fill_drain%0d: valid=%b byte=%h want 1 %h", i, out_valid, out_byte, fill_exp[i]);
      end
      tick();
    end
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_done: valid=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_lsb_first();
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    b_in_word   = 16'hBEEF;
    tick();
    b_in_valid = 1'b0;
    tick();
    vectors++;
    if ({b_out_valid, b_out_last, b_out_byte} !== {2'b10, 8'hEF}) begin
      miscompares++;
      $display("FAIL lsb_b0: valid=%b last=%b byte=%h want 1 0 ef", b_out_valid, b_out_last, b_out_byte);
    end
    tick();
    vectors++;
    if ({b_out_valid, b_out_last, b_out_byte} !== {2'b11, 8'hBE}) begin
      miscompares++;
      $display("FAIL lsb_b1: valid=%b last=%b byte=%h want 1 1 be", b_out_valid, b_out_last, b_out_byte);
    end
    tick();
    vectors++;
    if (b_out_valid !== 1'b0 || b_words_sent !== 8'd1) begin
      miscompares++;
      $display("FAIL lsb_done: valid=%b words_sent=%0d want 0 1", b_out_valid, b_words_sent);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid    = 1'($urandom_range(0, 1));
      in_word     = 16'($urandom);
      out_ready   = ($urandom_range(0, 3) != 0);
      b_in_valid  = 1'($urandom_range(0, 1));
      b_in_word   = 16'($urandom);
      b_out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid    = 1'b0;
    b_in_valid  = 1'b0;
    out_ready   = 1'b1;
    b_out_ready = 1'b1;
    for (int i = 0; i < 40 && (busy || b_busy); i++) tick();
    vectors++;
    if (busy !== 1'b0 || b_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL random_drain: busy=%b/%b want 0/0 within 40 cycles", busy, b_busy);
    end
  endtask

  task automatic test_wrap();
    int  sent = 0;
    logic accepted;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 3000 && sent < 256; cyc++) begin
      in_valid = 1'b1;
      in_word  = 16'($urandom);
      accepted = in_ready;
      tick();
      if (accepted) sent++;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20 && busy; i++) tick();
    vectors++;
    if (sent != 256 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_progress: accepted=%0d busy=%b want 256 0", sent, busy);
    end
    vectors++;
    if (words_sent !== 8'd0) begin
      miscompares++;
      $display("FAIL wrap_count: words_sent=%0d want 0", words_sent);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] words [3] = '{16'h1111, 16'hABCD, 16'h5555};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_word  = words[i];
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    vectors++;
    if ({out_valid, out_last, out_byte} !== {2'b11, 8'hCD} || words_sent !== 8'd1) begin
      miscompares++;
      $display("FAIL mid_pre: valid=%b last=%b byte=%h sent=%0d want 1 1 cd 1",
               out_valid, out_last, out_byte, words_sent);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({out_valid, out_last, busy, in_ready} !== 4'b0000 || out_byte !== 8'h00 || words_sent !== 8'd0) begin
      miscompares++;
      $display("FAIL mid_reset: valid/last/busy/in_ready=%b byte=%h sent=%0d want 0000 00 0",
               {out_valid, out_last, busy, in_ready}, out_byte, words_sent);
    end
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_release: in_ready=%b want 1", in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_quiet%0d: valid=%b busy=%b want 0 0", i, out_valid, busy);
      end
    end
  endtask

  initial begin
    in_valid = 1'b0;  in_word = '0;  out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_word = '0; b_out_ready = 1'b0;
    rst = 1'b1;
    test_reset();
    test_single();
    test_backpressure();
    test_fill();
    test_lsb_first();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
